axi_serial_bridge: RTL

AXI_SERIAL_BRIDGE -- requirements
Module: axi_serial_bridge

---
 rtl/fcpu_pkg.sv | 25 ++
 rtl/axi_serial_bridge.sv | 199 +++++++++++++++++++
 2 files changed

// File: rtl/fcpu_pkg.sv
// Shared AXI response codes, FSM state types and burst-length helper for the serial bridge.
package fcpu_pkg;

    localparam logic [1:0] RESP_OKAY   = 2'b00;
    localparam logic [1:0] RESP_SLVERR = 2'b10;

    typedef enum logic [1:0] {
        W_IDLE,
        W_DATA,
        W_PUSH,
        W_RESP
    } wr_state_t;

    typedef enum logic [1:0] {
        R_IDLE,
        R_WAIT,
        R_DATA
    } rd_state_t;

    // AXI len encodes beats-1; a 9-bit count holds 256 without wrapping.
    function automatic logic [8:0] beats_of(input logic [7:0] len);
        return {1'b0, len} + 9'd1;
    endfunction

endpackage

// File: rtl/axi_serial_bridge.sv
// AXI write bursts are streamed byte-wise to a serial transmitter; AXI reads pull bytes from a receiver.
// Optional `AXI_SERIAL_BRIDGE_STATUS_EN: reads with araddr[2]=1 return {rx_valid, tx_ready} instead of rx data.
module axi_serial_bridge
    import fcpu_pkg::*;
#(
    parameter int ID_W   = 4,
    parameter int ADDR_W = 32
) (
    input  logic              clk,
    input  logic              nrst,
    input  logic [ID_W-1:0]   io_awid,
    input  logic [ADDR_W-1:0] io_awaddr,
    input  logic [7:0]        io_awlen,
    input  logic              io_awvalid,
    output logic              io_awready,
    input  logic [7:0]        io_wdata,
    input  logic              io_wlast,
    input  logic              io_wvalid,
    output logic              io_wready,
    output logic [ID_W-1:0]   io_bid,
    output logic [1:0]        io_bresp,
    output logic              io_bvalid,
    input  logic              io_bready,
    input  logic [ID_W-1:0]   io_arid,
    input  logic [ADDR_W-1:0] io_araddr,
    input  logic [7:0]        io_arlen,
    input  logic              io_arvalid,
    output logic              io_arready,
    output logic [ID_W-1:0]   io_rid,
    output logic [7:0]        io_rdata,
    output logic [1:0]        io_rresp,
    output logic              io_rlast,
    output logic              io_rvalid,
    input  logic              io_rready,
    output logic [7:0]        tx_data,
    output logic              tx_valid,
    input  logic              tx_ready,
    input  logic [7:0]        rx_data,
    input  logic              rx_valid,
    output logic              rx_ready
);

    // ---------------- write path ----------------
    wr_state_t         r_wst, w_wst_nxt;
    logic [8:0]        r_wcnt, w_wcnt_nxt;
    logic [1:0]        r_bresp, w_bresp_nxt;
    logic [ID_W-1:0]   r_bid;
    logic [7:0]        r_tx_data;
    logic              r_wlast;
    logic              r_awready, r_wready, r_tx_valid, r_bvalid;
    logic              w_aw_hs, w_w_hs, w_tx_hs, w_b_hs;

    assign w_aw_hs = r_awready  && io_awvalid;
    assign w_w_hs  = r_wready   && io_wvalid;
    assign w_tx_hs = r_tx_valid && tx_ready;
    assign w_b_hs  = r_bvalid   && io_bready;

    always_comb begin
        w_wst_nxt   = r_wst;
        w_wcnt_nxt  = r_wcnt;
        w_bresp_nxt = r_bresp;
        case (r_wst)
            W_IDLE: if (w_aw_hs) begin
                w_wcnt_nxt = beats_of(io_awlen);
                w_wst_nxt  = W_DATA;
            end
            W_DATA: if (w_w_hs) w_wst_nxt = W_PUSH;
            W_PUSH: if (w_tx_hs) begin
                w_wcnt_nxt = r_wcnt - 9'd1;
                if (w_wcnt_nxt == '0 || r_wlast) begin
                    w_wst_nxt   = W_RESP;
                    // wlast must coincide exactly with the final counted beat
                    w_bresp_nxt = (r_wlast == (r_wcnt == 9'd1)) ? RESP_OKAY : RESP_SLVERR;
                end else begin
                    w_wst_nxt = W_DATA;
                end
            end
            W_RESP: if (w_b_hs) w_wst_nxt = W_IDLE;
            default: w_wst_nxt = W_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!nrst) begin
            r_wst      <= W_IDLE;
            r_wcnt     <= '0;
            r_bresp    <= RESP_OKAY;
            r_bid      <= '0;
            r_tx_data  <= '0;
            r_wlast    <= 1'b0;
            r_awready  <= 1'b0;
            r_wready   <= 1'b0;
            r_tx_valid <= 1'b0;
            r_bvalid   <= 1'b0;
        end else begin
            r_wst      <= w_wst_nxt;
            r_wcnt     <= w_wcnt_nxt;
            r_bresp    <= w_bresp_nxt;
            r_awready  <= (w_wst_nxt == W_IDLE);
            r_wready   <= (w_wst_nxt == W_DATA);
            r_tx_valid <= (w_wst_nxt == W_PUSH);
            r_bvalid   <= (w_wst_nxt == W_RESP);
            if (w_aw_hs) r_bid <= io_awid;
            if (w_w_hs) begin
                r_tx_data <= io_wdata;
                r_wlast   <= io_wlast;
            end
        end
    end

    // ---------------- read path ----------------
    rd_state_t         r_rst, w_rst_nxt;
    logic [8:0]        r_rcnt, w_rcnt_nxt;
    logic [ID_W-1:0]   r_rid;
    logic [ADDR_W-1:0] r_raddr;
    logic [7:0]        r_rdata;
    logic              r_arready, r_rx_ready, r_rvalid, r_rlast;
    logic              w_ar_hs, w_rx_hs, w_r_hs;
    logic              w_ar_status, w_rd_status, w_stat_cap;
    logic              w_unused;

    assign w_ar_hs = r_arready  && io_arvalid;
    assign w_rx_hs = r_rx_ready && rx_valid;
    assign w_r_hs  = r_rvalid   && io_rready;

`ifdef AXI_SERIAL_BRIDGE_STATUS_EN
    assign w_ar_status = io_araddr[2];
    assign w_rd_status = r_raddr[2];
`else
    assign w_ar_status = 1'b0;
    assign w_rd_status = 1'b0;
`endif

    // Status beats are resampled at every entry into R_DATA.
    assign w_stat_cap = (w_ar_hs && w_ar_status) || (w_r_hs && w_rd_status && w_rcnt_nxt != '0);
    assign w_unused   = ^{io_awaddr, r_raddr};

    always_comb begin
        w_rst_nxt  = r_rst;
        w_rcnt_nxt = r_rcnt;
        case (r_rst)
            R_IDLE: if (w_ar_hs) begin
                w_rcnt_nxt = beats_of(io_arlen);
                w_rst_nxt  = w_ar_status ? R_DATA : R_WAIT;
            end
            R_WAIT: if (w_rx_hs) w_rst_nxt = R_DATA;
            R_DATA: if (w_r_hs) begin
                w_rcnt_nxt = r_rcnt - 9'd1;
                if (w_rcnt_nxt == '0)  w_rst_nxt = R_IDLE;
                else if (w_rd_status)  w_rst_nxt = R_DATA;
                else                   w_rst_nxt = R_WAIT;
            end
            default: w_rst_nxt = R_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!nrst) begin
            r_rst      <= R_IDLE;
            r_rcnt     <= '0;
            r_rid      <= '0;
            r_raddr    <= '0;
            r_rdata    <= '0;
            r_arready  <= 1'b0;
            r_rx_ready <= 1'b0;
            r_rvalid   <= 1'b0;
            r_rlast    <= 1'b0;
        end else begin
            r_rst      <= w_rst_nxt;
            r_rcnt     <= w_rcnt_nxt;
            r_arready  <= (w_rst_nxt == R_IDLE);
            r_rx_ready <= (w_rst_nxt == R_WAIT);
            r_rvalid   <= (w_rst_nxt == R_DATA);
            r_rlast    <= (w_rst_nxt == R_DATA) && (w_rcnt_nxt == 9'd1);
            if (w_ar_hs) begin
                r_rid   <= io_arid;
                r_raddr <= io_araddr;
            end
            if (w_rx_hs)         r_rdata <= rx_data;
            else if (w_stat_cap) r_rdata <= {6'b0, rx_valid, tx_ready};
        end
    end

    assign io_awready = r_awready;
    assign io_wready  = r_wready;
    assign io_bid     = r_bid;
    assign io_bresp   = r_bresp;
    assign io_bvalid  = r_bvalid;
    assign tx_data    = r_tx_data;
    assign tx_valid   = r_tx_valid;
    assign io_arready = r_arready;
    assign io_rid     = r_rid;
    assign io_rdata   = r_rdata;
    assign io_rresp   = RESP_OKAY;
    assign io_rlast   = r_rlast;
    assign io_rvalid  = r_rvalid;
    assign rx_ready   = r_rx_ready;

endmodule
